// File: rtl/cordic_cmp_pkg.sv
// Shared types and helpers for the CORDIC comparator arbiter.
package cordic_cmp_pkg;

  localparam int CMP_W    = 32;
  localparam int ID_MAX_W = 8;

  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

  typedef struct packed {
    logic                gr;
    logic                lt;
    logic                eq;
    logic [ID_MAX_W-1:0] id;
  } cmp_result_t;

  // Flipping the MSB maps two's-complement order onto unsigned order.
  function automatic logic [CMP_W-1:0] sign_bias(input logic [CMP_W-1:0] v, input logic s);
    return v ^ {s, {(CMP_W-1){1'b0}}};
  endfunction

endpackage

// File: rtl/comparator32b.sv
// Unsigned 32-bit magnitude comparator.
module comparator32b (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        gr,
  output logic        lt,
  output logic        eq
);

  assign eq = (a == b);
  assign gr = (a > b);
  assign lt = ~gr & ~eq;

endmodule

// File: rtl/cordic_rr_arbiter.sv
// Combinational round-robin pick: first set request after ptr, wrapping.
module cordic_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx
);

  // Scan farthest-to-nearest so the nearest requester after ptr wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    if (en) begin
      for (int k = NUM_REQ; k >= 1; k--) begin
        if (req[(int'(ptr) + k) % NUM_REQ]) begin
          grant = '0;
          grant[(int'(ptr) + k) % NUM_REQ] = 1'b1;
          idx = ID_W'((int'(ptr) + k) % NUM_REQ);
        end
      end
    end
  end

endmodule

// File: rtl/cordic_cmp_arbiter.sv
// Time-shares one 32-bit comparator among NUM_REQ CORDIC clients with
// round-robin grant, a registered operand stage and a tagged response port.
module cordic_cmp_arbiter
  import cordic_cmp_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0][CMP_W-1:0]   req_a,
  input  logic [NUM_REQ-1:0][CMP_W-1:0]   req_b,
  input  logic [NUM_REQ-1:0]              req_signed,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [ID_W-1:0]                 rsp_id,
  output logic                            rsp_gr,
  output logic                            rsp_lt,
  output logic                            rsp_eq,
  output logic                            busy,
  output logic [CNT_W-1:0]                cmp_count
);

  state_t             state;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    win_idx;
  logic [NUM_REQ-1:0] grant;
  logic               accept_win;
  logic               accept;
  logic [CMP_W-1:0]   op_a;
  logic [CMP_W-1:0]   op_b;
  logic               op_s;
  logic [ID_W-1:0]    op_id;
  logic [CMP_W-1:0]   bias_a;
  logic [CMP_W-1:0]   bias_b;
  logic               c_gr;
  logic               c_lt;
  logic               c_eq;
  cmp_result_t        rsp_q;

  // Grants only while idle or while the pending result is being drained.
  assign accept_win = ~rst & ((state == IDLE) | ((state == RESP) & rsp_ready));
  assign accept     = |grant;
  assign req_ready  = grant;

  cordic_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .en    (accept_win),
    .grant (grant),
    .idx   (win_idx)
  );

  assign bias_a = sign_bias(op_a, op_s);
  assign bias_b = sign_bias(op_b, op_s);

  comparator32b u_cmp (
    .a  (bias_a),
    .b  (bias_b),
    .gr (c_gr),
    .lt (c_lt),
    .eq (c_eq)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= ID_W'(NUM_REQ - 1);
      op_a      <= '0;
      op_b      <= '0;
      op_s      <= 1'b0;
      op_id     <= '0;
      rsp_q     <= '0;
      rsp_valid <= 1'b0;
      cmp_count <= '0;
    end else begin
      case (state)
        IDLE: state <= accept ? EVAL : IDLE;
        EVAL: begin
          rsp_q.gr  <= c_gr;
          rsp_q.lt  <= c_lt;
          rsp_q.eq  <= c_eq;
          rsp_q.id  <= ID_MAX_W'(op_id);
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            if (cmp_count != {CNT_W{1'b1}}) cmp_count <= cmp_count + 1'b1;
            rsp_valid <= 1'b0;
            state     <= accept ? EVAL : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (accept) begin
        op_a   <= req_a[win_idx];
        op_b   <= req_b[win_idx];
        op_s   <= req_signed[win_idx];
        op_id  <= win_idx;
        rr_ptr <= win_idx;
      end
    end
  end

  assign busy   = (state != IDLE);
  assign rsp_id = rsp_q.id[ID_W-1:0];
  assign rsp_gr = rsp_q.gr;
  assign rsp_lt = rsp_q.lt;
  assign rsp_eq = rsp_q.eq;

endmodule
